// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes, FSM states and
// the down-counter width helper.
package mips_muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MUL  = 3'd1;
  localparam state_t S_DIV  = 3'd2;
  localparam state_t S_FIX  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Wide enough to hold the iteration count WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One combinational restoring-division step on unsigned magnitudes: shift the
// next dividend bit into the partial remainder and try subtracting the divisor.
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < dsr always holds, so the shifted remainder needs only one extra bit.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, dsr});
  assign diff     = shifted - {1'b0, dsr};
  assign rem_next = fits ? WIDTH'(diff) : WIDTH'(shifted);
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO, with a pipeline stall
// request while an operation is in flight.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_ITER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q, a_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_q, rneg_q, zero_q, ovf_q, dbz_q;

  // Input decode and operand magnitudes
  logic             start_ok, div_in, signed_in, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fast;

  assign start_ok  = (state_q == S_IDLE) & start_i & ~cancel_i;
  assign div_in    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign signed_in = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign sa        = signed_in & a_i[WIDTH-1];
  assign sb        = signed_in & b_i[WIDTH-1];
  assign mag_a     = sa ? -a_i : a_i;
  assign mag_b     = sb ? -b_i : b_i;
  assign prod_fast = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};

  // Iterative shift-add multiply: {rem_q, quo_q} is the running product,
  // quo_q's low bit is the current multiplier bit, dsr_q the multiplicand.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_rem_n, mul_quo_n;

  assign mul_sum   = {1'b0, rem_q} + {1'b0, dsr_q & {WIDTH{quo_q[0]}}};
  assign mul_rem_n = mul_sum[WIDTH:1];
  assign mul_quo_n = {mul_sum[0], quo_q[WIDTH-1:1]};

  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  mips_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dsr      (dsr_q),
    .rem_next (div_rem_n),
    .quo_next (div_quo_n)
  );

  // Sign application and special cases
  logic [2*WIDTH-1:0] prod_mag, prod_sgn;
  logic [WIDTH-1:0]   q_sgn, r_sgn, fix_hi, fix_lo;

  assign prod_mag = {rem_q, quo_q};
  assign prod_sgn = neg_q ? -prod_mag : prod_mag;
  assign q_sgn    = neg_q ? -quo_q : quo_q;
  assign r_sgn    = rneg_q ? -rem_q : rem_q;

  always_comb begin
    fix_hi = prod_sgn[2*WIDTH-1:WIDTH];
    fix_lo = prod_sgn[WIDTH-1:0];
    if (div_q) begin
      if (zero_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else if (ovf_q) begin
        fix_hi = '0;
        fix_lo = MIN_VAL;
      end else begin
        fix_hi = r_sgn;
        fix_lo = q_sgn;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (div_in)             state_d = S_DIV;
          else if (MUL_ITER != 0) state_d = S_MUL;
          else                    state_d = S_FIX;
        end
      end
      S_MUL, S_DIV: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:        state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (cancel_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            div_q  <= div_in;
            a_q    <= a_i;
            dsr_q  <= mag_b;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            zero_q <= (b_i == '0);
            ovf_q  <= signed_in & div_in & (a_i == MIN_VAL) & (&b_i);
            cnt_q  <= CW'(WIDTH);
            if (div_in || MUL_ITER != 0) begin
              rem_q <= '0;
              quo_q <= mag_a;
            end else begin
              rem_q <= prod_fast[2*WIDTH-1:WIDTH];
              quo_q <= prod_fast[WIDTH-1:0];
            end
          end
        end
        S_MUL: begin
          rem_q <= mul_rem_n;
          quo_q <= mul_quo_n;
          cnt_q <= cnt_q - 1'b1;
        end
        S_DIV: begin
          rem_q <= div_rem_n;
          quo_q <= div_quo_n;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          // A flush in FIX must leave the architectural HI/LO untouched.
          if (!cancel_i) begin
            hi_q  <= fix_hi;
            lo_q  <= fix_lo;
            dbz_q <= div_q & zero_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign div_by_zero_o = done_o & dbz_q;
  assign stall_o       = start_ok | (state_q == S_MUL) | (state_q == S_DIV) |
                         (state_q == S_FIX);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
